// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch controller:
//   - sw_state_e  : controller state encoding
//   - sw_time_t   : mm:ss.cc time as six packed BCD digits
//   - digit limits, disp field offsets, and BCD helper functions
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int DISP_W  = 6 * DIGIT_W;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;  // units digits and centisecond tens
    localparam bcd_t TENS_MAX  = 4'd5;  // tens of seconds / tens of minutes

    // Bit offsets of each digit inside the display word.
    localparam int OFF_CS_O  = 0;
    localparam int OFF_CS_T  = 4;
    localparam int OFF_SEC_O = 8;
    localparam int OFF_SEC_T = 12;
    localparam int OFF_MIN_O = 16;
    localparam int OFF_MIN_T = 20;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE,
        DONE
    } sw_state_e;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
        bcd_t cs_t;
        bcd_t cs_o;
    } sw_time_t;

    localparam sw_time_t TIME_MAX = '{min_t: 4'd5, min_o: 4'd9,
                                      sec_t: 4'd5, sec_o: 4'd9,
                                      cs_t:  4'd9, cs_o:  4'd9};

    // One BCD digit step: returns {next_digit, carry_out}. With cin low the
    // digit passes through unchanged and no carry is produced.
    function automatic logic [DIGIT_W:0] bcd_step(bcd_t d, bcd_t lim, logic cin);
        if (!cin)
            return {d, 1'b0};
        if (d == lim)
            return {bcd_t'(0), 1'b1};
        return {d + bcd_t'(1), 1'b0};
    endfunction

    // Place each digit at its display offset.
    function automatic logic [DISP_W-1:0] to_disp(sw_time_t t);
        logic [DISP_W-1:0] d;
        d = '0;
        d[OFF_CS_O  +: DIGIT_W] = t.cs_o;
        d[OFF_CS_T  +: DIGIT_W] = t.cs_t;
        d[OFF_SEC_O +: DIGIT_W] = t.sec_o;
        d[OFF_SEC_T +: DIGIT_W] = t.sec_t;
        d[OFF_MIN_O +: DIGIT_W] = t.min_o;
        d[OFF_MIN_T +: DIGIT_W] = t.min_t;
        return d;
    endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// -----------------------------------------------------------------------------
// stopwatch_controller_if
// Button pulses in, display word and status flags out.
//   start_stop, lap, clear : single-cycle button pulses (master -> slave)
//   disp                   : {min_t,min_o,sec_t,sec_o,cs_t,cs_o} BCD word
//   running, lap_active, overflow : status flags (slave -> master)
// master = button/display side, slave = stopwatch controller.
// -----------------------------------------------------------------------------
interface stopwatch_controller_if;
    import stopwatch_pkg::*;

    logic              start_stop;
    logic              lap;
    logic              clear;
    logic [DISP_W-1:0] disp;
    logic              running;
    logic              lap_active;
    logic              overflow;

    modport master (
        output start_stop, lap, clear,
        input  disp, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
        output disp, running, lap_active, overflow
    );

endinterface

// File: rtl/stopwatch_controller_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk by DIV into a one-cycle tick while enabled.
//   clk  : board clock
//   rst  : asynchronous active-low reset
//   en   : count enable; when low the count holds its value
//   clr  : synchronous clear, overrides en
//   tick : high while enabled and the count sits at DIV-1
// DIV must be at least 2.
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
// Start/pause/lap/clear stopwatch with an mm:ss.cc BCD time count.
//   clk : board clock (only domain)
//   rst : asynchronous active-low reset
//   sw  : stopwatch_controller_if.slave
//         in : start_stop, lap, clear pulses (priority clear > start_stop > lap)
//         out: disp (registered, lap-frozen in LAP), running, lap_active,
//              overflow
// The internal prescaler produces a centisecond tick; the time saturates at
// 59:59.99 and a further tick parks the controller in DONE until clear.
// -----------------------------------------------------------------------------
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_FREQUENCY_IN_HZ        = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    stopwatch_controller_if.slave  sw
);

    localparam int TICK_DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;

    sw_state_e state;
    sw_time_t  tm;       // live time
    sw_time_t  frz;      // lap-freeze copy
    sw_time_t  tm_inc;   // tm + 1 cs
    logic [4:0] cy;      // digit carries, cs_o upward
    logic      tick;
    logic      at_max;
    logic      pre_en;
    logic      pre_clr;

    // Prescaler runs in RUN/LAP, holds in PAUSE, and is zeroed in IDLE/DONE
    // so that a start from IDLE always begins a full period.
    assign pre_en  = (state == RUN) || (state == LAP);
    assign pre_clr = sw.clear || (state == IDLE) || (state == DONE);

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign at_max = (tm == TIME_MAX);

    // Ripple BCD increment. min_t never wraps: the at_max guard keeps the
    // increment from being applied at 59:59.99.
    always_comb begin
        tm_inc = tm;
        cy     = '0;
        {tm_inc.cs_o,  cy[0]} = bcd_step(tm.cs_o,  DIGIT_MAX, 1'b1);
        {tm_inc.cs_t,  cy[1]} = bcd_step(tm.cs_t,  DIGIT_MAX, cy[0]);
        {tm_inc.sec_o, cy[2]} = bcd_step(tm.sec_o, DIGIT_MAX, cy[1]);
        {tm_inc.sec_t, cy[3]} = bcd_step(tm.sec_t, TENS_MAX,  cy[2]);
        {tm_inc.min_o, cy[4]} = bcd_step(tm.min_o, DIGIT_MAX, cy[3]);
        tm_inc.min_t = tm.min_t + bcd_t'(cy[4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tm            <= '0;
            frz           <= '0;
            sw.disp       <= '0;
            sw.running    <= 1'b0;
            sw.lap_active <= 1'b0;
            sw.overflow   <= 1'b0;
        end else begin
            // Display follows the current registers, one cycle behind them.
            sw.disp <= to_disp((state == LAP) ? frz : tm);

            if (sw.clear) begin
                state         <= IDLE;
                tm            <= '0;
                sw.running    <= 1'b0;
                sw.lap_active <= 1'b0;
                sw.overflow   <= 1'b0;
            end else if (tick && at_max) begin
                // Saturate: time holds, buttons in this cycle are dropped.
                state         <= DONE;
                sw.running    <= 1'b0;
                sw.lap_active <= 1'b0;
                sw.overflow   <= 1'b1;
            end else begin
                if (tick)
                    tm <= tm_inc;

                case (state)
                    IDLE: begin
                        if (sw.start_stop) begin
                            state      <= RUN;
                            sw.running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (sw.start_stop) begin
                            state      <= PAUSE;
                            sw.running <= 1'b0;
                        end else if (sw.lap) begin
                            // Pre-increment value even if a tick lands now.
                            state         <= LAP;
                            frz           <= tm;
                            sw.lap_active <= 1'b1;
                        end
                    end
                    LAP: begin
                        if (sw.start_stop) begin
                            state         <= PAUSE;
                            sw.running    <= 1'b0;
                            sw.lap_active <= 1'b0;
                        end else if (sw.lap) begin
                            state         <= RUN;
                            sw.lap_active <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (sw.start_stop) begin
                            state      <= RUN;
                            sw.running <= 1'b1;
                        end
                    end
                    DONE: ;
                    default: begin
                        state         <= IDLE;
                        sw.running    <= 1'b0;
                        sw.lap_active <= 1'b0;
                        sw.overflow   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
